flag_event_rx: RTL and testbench

//   Receive end of the toggle-flag crossing. Accepts a toggle from a foreign

---
 rtl/flag_event_rx.sv | 102 ++++++++++
 tb/tb_flag_event_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_event_rx.sv
// Receive side of a toggle-flag crossing: synchronizes toggle_in, turns each edge into a
// queued event on a valid/ready handshake, and returns an ack toggle as source busy feedback.
`timescale 1ns/1ps
module flag_event_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_WIDTH     = 4,
  parameter int ACK_ON_ACCEPT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 toggle_in,
  output logic                 ack_toggle_out,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam logic [PW-1:0]        PRIME_LAST = PW'(SYNC_STAGES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic {PRIME, RUN} state_t;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
  logic                 hist;
  logic                 det;
  logic                 accept;
  logic                 ack_evt;
  logic                 lost;
  state_t               state, state_nxt;
  logic [PW-1:0]        prime_cnt, prime_cnt_nxt;
  logic                 ack_nxt;
  logic [CNT_WIDTH-1:0] pending_nxt;
  logic                 overflow_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], toggle_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign det         = sync[SYNC_STAGES-1] ^ hist;
  assign event_valid = (pending != '0);
  assign accept      = event_valid & event_ready;
  assign ack_evt     = (ACK_ON_ACCEPT != 0) ? accept : det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= PRIME;
      prime_cnt      <= '0;
      ack_toggle_out <= 1'b0;
      pending        <= '0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_nxt;
      prime_cnt      <= prime_cnt_nxt;
      ack_toggle_out <= ack_nxt;
      pending        <= pending_nxt;
      overflow       <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    ack_nxt       = ack_toggle_out;
    pending_nxt   = pending;
    overflow_nxt  = overflow;
    lost          = 1'b0;
    case (state)
      PRIME: begin
        // Align the ack with whatever level the source already holds so it does not stay busy.
        if (prime_cnt == PRIME_LAST) begin
          state_nxt     = RUN;
          prime_cnt_nxt = '0;
          ack_nxt       = sync[SYNC_STAGES-1];
        end else begin
          prime_cnt_nxt = prime_cnt + 1'b1;
        end
      end
      RUN: begin
        if (det && !accept) begin
          if (pending == CNT_MAX) lost = 1'b1;
          else                    pending_nxt = pending + 1'b1;
        end else if (!det && accept) begin
          pending_nxt = pending - 1'b1;
        end
        if (ack_evt) ack_nxt = ~ack_toggle_out;
      end
      default: state_nxt = PRIME;
    endcase
    if (lost)              overflow_nxt = 1'b1;
    else if (overflow_clr) overflow_nxt = 1'b0;
  end

endmodule

// File: tb/tb_flag_event_rx.sv
// Scoreboard bench for flag_event_rx: stimulus pushes the pending count each accept should see.
`timescale 1ns/1ps
module tb_flag_event_rx;

  logic clk = 1'b0;
  logic clka = 1'b0;
  real  clka_half = 1.7;
  logic rst;

  logic       a_tog, a_ack, a_valid, a_ready, a_ovf, a_clr;
  logic [1:0] a_pend;
  logic       b_tog, b_ack, b_valid, b_ready, b_ovf, b_clr;
  logic [3:0] b_pend;
  logic       dir_b_ready, rnd_ready, stress;

  int n_checks = 0;
  int n_errors = 0;
  int b_acc = 0;
  int q_a[$];
  int q_b[$];

  assign b_ready = stress ? rnd_ready : dir_b_ready;

  flag_event_rx #(.SYNC_STAGES(2), .CNT_WIDTH(2), .ACK_ON_ACCEPT(0)) dut_a (
    .clk(clk), .rst(rst), .toggle_in(a_tog), .ack_toggle_out(a_ack),
    .event_valid(a_valid), .event_ready(a_ready), .pending(a_pend),
    .overflow(a_ovf), .overflow_clr(a_clr));

  flag_event_rx #(.SYNC_STAGES(2), .CNT_WIDTH(4), .ACK_ON_ACCEPT(1)) dut_b (
    .clk(clk), .rst(rst), .toggle_in(b_tog), .ack_toggle_out(b_ack),
    .event_valid(b_valid), .event_ready(b_ready), .pending(b_pend),
    .overflow(b_ovf), .overflow_clr(b_clr));

  always #5 clk = ~clk;
  initial forever #(clka_half) clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rnd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Accepts are observed mid-cycle; the accept itself happens at the next posedge.
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_accept", 32'(a_pend), 32'hFFFF_FFFF);
      else chk("a_accept_pending", 32'(a_pend), 32'(q_a.pop_front()));
    end
    if (!rst && b_valid && b_ready) begin
      if (stress) b_acc++;
      if (q_b.size() == 0) chk("b_unexpected_accept", 32'(b_pend), 32'hFFFF_FFFF);
      else chk("b_accept_pending", 32'(b_pend), 32'(q_b.pop_front()));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ack;
    int sent;
    int total;
    int guard;
    logic ack_s1, ack_s2;
    rst = 1'b1; stress = 1'b0;
    a_tog = 1'b1; a_ready = 1'b0; a_clr = 1'b0;
    b_tog = 1'b1; dir_b_ready = 1'b0; b_clr = 1'b0;
    repeat (3) tick();
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_a_pending", 32'(a_pend), 0);
    chk("rst_a_overflow", 32'(a_ovf), 0);
    chk("rst_b_ack", 32'(b_ack), 0);

    // Toggle held high through reset: no event, ack follows after 3 edges.
    rst = 1'b0;
    tick(); chk("prime_e1_ack", 32'(a_ack), 0);
    tick(); chk("prime_e2_ack", 32'(a_ack), 0);
    tick(); chk("prime_e3_ack_a", 32'(a_ack), 1);
    chk("prime_e3_ack_b", 32'(b_ack), 1);
    repeat (3) tick();
    chk("prime_no_event_a", 32'(a_valid), 0);
    chk("prime_no_event_b", 32'(b_valid), 0);
    exp_ack = 1;

    // Latency: valid rises two edges after first sample.
    a_ready = 1'b1;
    q_a.push_back(1);
    a_tog = 1'b0;
    tick(); tick();
    chk("lat_e1_valid", 32'(a_valid), 0);
    tick();
    chk("lat_e2_valid", 32'(a_valid), 1);
    exp_ack ^= 1;
    chk("lat_e2_ack", 32'(a_ack), 32'(exp_ack));
    tick();
    chk("lat_e3_pending", 32'(a_pend), 0);
    a_ready = 1'b0;

    // Detection and accept on the same edge leaves pending unchanged.
    q_a.push_back(1);
    a_tog = 1'b1;
    repeat (3) tick();
    chk("da_pre_pending", 32'(a_pend), 1);
    exp_ack ^= 1;
    chk("da_pre_ack", 32'(a_ack), 32'(exp_ack));
    q_a.push_back(1);
    a_tog = 1'b0;
    tick(); tick();
    a_ready = 1'b1;
    tick();
    chk("da_pending", 32'(a_pend), 1);
    exp_ack ^= 1;
    chk("da_ack", 32'(a_ack), 32'(exp_ack));
    tick();
    chk("da_drain_pending", 32'(a_pend), 0);
    chk("da_drain_ack", 32'(a_ack), 32'(exp_ack));
    a_ready = 1'b0;

    // Saturation at 3 with a 2-bit counter; dropped events still ack.
    for (int i = 0; i < 4; i++) begin
      a_tog = ~a_tog;
      repeat (3) tick();
      exp_ack ^= 1;
      chk("sat_pending", 32'(a_pend), (i < 3) ? i + 1 : 3);
      chk("sat_overflow", 32'(a_ovf), (i == 3) ? 1 : 0);
    end
    chk("sat_ack", 32'(a_ack), 32'(exp_ack));
    a_tog = ~a_tog;
    tick(); tick();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    exp_ack ^= 1;
    chk("clr_set_overflow", 32'(a_ovf), 1);
    chk("clr_set_pending", 32'(a_pend), 3);
    chk("clr_set_ack", 32'(a_ack), 32'(exp_ack));
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_overflow", 32'(a_ovf), 0);
    q_a.push_back(3); q_a.push_back(2); q_a.push_back(1);
    a_ready = 1'b1;
    repeat (3) tick();
    chk("sat_drain_pending", 32'(a_pend), 0);
    a_ready = 1'b0;

    // Reset with an event pending: discarded, then re-prime onto new level.
    a_tog = ~a_tog;
    repeat (3) tick();
    chk("mid_pre_pending", 32'(a_pend), 1);
    rst = 1'b1;
    a_tog = ~a_tog;
    tick();
    chk("mid_rst_pending", 32'(a_pend), 0);
    chk("mid_rst_ack", 32'(a_ack), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_prime_ack", 32'(a_ack), 32'(a_tog));
    tick();
    chk("mid_prime_valid", 32'(a_valid), 0);

    // Ack on accept: held until consumer takes the event.
    q_b.push_back(1);
    b_tog = 1'b0;
    repeat (4) tick();
    chk("aoa_pending", 32'(b_pend), 1);
    chk("aoa_ack_held", 32'(b_ack), 1);
    dir_b_ready = 1'b1;
    tick();
    dir_b_ready = 1'b0;
    chk("aoa_ack_accept", 32'(b_ack), 0);
    chk("aoa_pending_after", 32'(b_pend), 0);

    // Source model in a foreign clock, busy until the ack returns.
    stress = 1'b1;
    total = 0;
    ack_s1 = b_ack; ack_s2 = b_ack;
    for (int r = 0; r < 2; r++) begin
      clka_half = (r == 0) ? 1.7 : 15.0;
      sent = 0;
      guard = 0;
      while (sent < 500 && guard < 10000) begin
        @(posedge clka);
        guard++;
        ack_s2 = ack_s1;
        ack_s1 = b_ack;
        if (b_tog == ack_s2 && $urandom_range(0, 1) == 1) begin
          b_tog = ~b_tog;
          q_b.push_back(1);
          sent++;
          total++;
        end
      end
      if (sent < 500) chk("stress_budget", 32'(sent), 500);
    end
    guard = 0;
    while (q_b.size() != 0 && guard < 1000) begin
      tick();
      guard++;
    end
    tick();
    stress = 1'b0;
    chk("stress_drained", 32'(q_b.size()), 0);
    chk("stress_accept_count", 32'(b_acc), 32'(total));
    chk("stress_overflow", 32'(b_ovf), 0);
    chk("stress_pending", 32'(b_pend), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
